// File: rtl/sum_bcd_converter.sv
// Binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: start sampled at E0, shifts at E1..E_IN_WIDTH, done pulses the cycle after (IN_WIDTH+1 edges).
// Backpressure: none; start is ignored while busy, accepted again in the done cycle.
module sum_bcd_converter #(
    parameter int IN_WIDTH = 5,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   sum_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [IN_WIDTH-1:0] shreg;
    logic [IN_WIDTH-1:0] shreg_nxt;
    logic [BW-1:0]       scratch;
    logic [BW-1:0]       scratch_adj;
    logic [BW-1:0]       scratch_nxt;
    logic                sticky;
    logic                carry_out;
    logic                top_ge10;
    logic [CW-1:0]       cnt;
    logic                last_shift;

    // The counter reaching 1 while shifting marks the final shift of this conversion.
    assign last_shift = (state == SHIFT) && (cnt == CW'(1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE on start, return after the last shift.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 adjustment of every digit >= 5, then the one-bit left shift of {scratch, shreg}.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_nxt = {scratch_adj[BW-2:0], shreg[IN_WIDTH-1]};
        shreg_nxt   = shreg << 1;
        carry_out   = scratch_adj[BW-1];
        // A top digit above 9 after the final shift also means the value did not fit.
        top_ge10    = (scratch_nxt[BW-1 -: 4] >= 4'd10);
    end

    // Datapath: load on accepted start, shift while busy, publish result on the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            scratch  <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            bcd_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= sum_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CW'(IN_WIDTH);
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg_nxt;
                    sticky  <= sticky | carry_out;
                    cnt     <= cnt - CW'(1);
                    if (last_shift) begin
                        bcd_out  <= scratch_nxt;
                        overflow <= sticky | carry_out | top_ge10;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_bcd_converter.sv
module tb_sum_bcd_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] sum_in;
    logic [7:0] bcd;
    logic       busy, done, ovf;

    logic       start2;
    logic [6:0] sum2;
    logic [7:0] bcd2;
    logic       busy2, done2, ovf2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sum_bcd_converter #(.IN_WIDTH(5), .DIGITS(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sum_in   (sum_in),
        .bcd_out  (bcd),
        .busy     (busy),
        .done     (done),
        .overflow (ovf)
    );

    sum_bcd_converter #(.IN_WIDTH(7), .DIGITS(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .sum_in   (sum2),
        .bcd_out  (bcd2),
        .busy     (busy2),
        .done     (done2),
        .overflow (ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on the default instance, observed over a bounded 14-edge window.
    // Edge index 1 is the edge that samples start.
    task automatic run_a(input logic [4:0] v, output int first, output int ndone,
                         output int nbusy, output logic [7:0] got, output logic gov);
        sum_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        first  = -1;
        ndone  = 0;
        nbusy  = 0;
        got    = 8'hEE;
        gov    = 1'b1;
        if (busy) nbusy++;
        if (done) ndone++;
        for (int k = 2; k <= 14; k++) begin
            tick();
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    got   = bcd;
                    gov   = ovf;
                end
            end
        end
    endtask

    initial begin
        int         first, nd, nb, k, k2, nlow;
        logic [7:0] got, exp;
        logic       gov;

        rst_n  = 1'b0;
        start  = 1'b0;
        sum_in = '0;
        start2 = 1'b0;
        sum2   = '0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",  bcd,  8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf",  ovf,  1'b0);
        check("rst_bcd2", bcd2, 8'h00);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        repeat (10) begin
            tick();
            if (done) nd++;
            if (busy) nb++;
        end
        check("idle_done", nd,   0);
        check("idle_busy", nb,   0);
        check("idle_bcd",  bcd,  8'h00);
        check("idle_ovf",  ovf,  1'b0);

        // Exhaustive default range.
        for (int v = 0; v < 32; v++) begin
            exp = {4'(v / 10), 4'(v % 10)};
            run_a(5'(v), first, nd, nb, got, gov);
            check($sformatf("lat_%0d",   v), first, 6);
            check($sformatf("ndone_%0d", v), nd,    1);
            check($sformatf("nbusy_%0d", v), nb,    5);
            check($sformatf("bcd_%0d",   v), got,   exp);
            check($sformatf("ovf_%0d",   v), gov,   1'b0);
            check($sformatf("hold_%0d",  v), bcd,   exp);
        end

        // Hand-computed corner vectors.
        run_a(5'd19, first, nd, nb, got, gov);
        check("v19", got, 8'h19);
        run_a(5'd30, first, nd, nb, got, gov);
        check("v30", got, 8'h30);
        run_a(5'd31, first, nd, nb, got, gov);
        check("v31", got, 8'h31);

        // Start while busy is ignored.
        sum_in = 5'd12;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        sum_in = 5'd27;
        tick();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        first  = -1;
        nd     = 0;
        got    = 8'hEE;
        for (int kk = 4; kk <= 16; kk++) begin
            tick();
            if (done) begin
                nd++;
                if (first < 0) begin
                    first = kk;
                    got   = bcd;
                end
            end
        end
        check("busy_ign_lat",   first, 6);
        check("busy_ign_ndone", nd,    1);
        check("busy_ign_bcd",   got,   8'h12);
        check("busy_ign_idle",  busy,  1'b0);

        // Back-to-back: start held in the done cycle.
        sum_in = 5'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        k = 0;
        while (!done && k < 12) begin
            tick();
            k++;
        end
        check("b2b_done1", done, 1'b1);
        check("b2b_lat1",  k,    5);
        check("b2b_bcd1",  bcd,  8'h07);
        check("b2b_busy1", busy, 1'b0);
        start  = 1'b1;
        sum_in = 5'd25;
        k2   = 0;
        nlow = 0;
        do begin
            tick();
            k2++;
            if (!busy && !done) nlow++;
        end while (!done && k2 < 12);
        start = 1'b0;
        check("b2b_done2", done, 1'b1);
        check("b2b_gap",   k2,   6);
        check("b2b_bcd2",  bcd,  8'h25);
        check("b2b_low",   nlow, 0);
        tick();
        check("b2b_pulse", done, 1'b0);
        check("b2b_stop",  busy, 1'b0);

        // Asynchronous reset mid-conversion.
        sum_in = 5'd29;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        check("mid_hold_bcd", bcd,  8'h25);
        check("mid_busy_pre", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd",  bcd,  8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_ovf",  ovf,  1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            tick();
            if (done) nd++;
        end
        check("mid_no_done", nd, 0);
        run_a(5'd5, first, nd, nb, got, gov);
        check("mid_after_lat", first, 6);
        check("mid_after_bcd", got,   8'h05);

        // Overflow on the 7-bit instance.
        sum2   = 7'd127;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 1;
        while (!done2 && k < 20) begin
            tick();
            k++;
        end
        check("ov127_done", done2, 1'b1);
        check("ov127_lat",  k,     8);
        check("ov127_bcd",  bcd2,  8'h27);
        check("ov127_ovf",  ovf2,  1'b1);
        tick();
        check("ov127_pulse", done2, 1'b0);

        sum2   = 7'd99;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 1;
        while (!done2 && k < 20) begin
            tick();
            k++;
        end
        check("ov99_done", done2, 1'b1);
        check("ov99_lat",  k,     8);
        check("ov99_bcd",  bcd2,  8'h99);
        check("ov99_ovf",  ovf2,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly downstream of the four-bit adder. It consumes the adder's 5-bit sum (0..30 for 4-bit operands; the full 5-bit range is 0..31).
- Produces packed decimal digits for the lab's two-digit seven-segment display path.
- Start/busy/done handshake, so the display stage knows when the digits are fresh.

Parameters:
- IN_WIDTH, 5: width of the binary input; the default matches the adder sum.
- DIGITS, 2: number of BCD output digits.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a conversion; sampled on the rising edge.
- sum_in, input, IN_WIDTH: binary value to convert; sampled only when start is accepted.
- bcd_out, output, 4*DIGITS: packed BCD result; digit 0 (ones) in [3:0], digit 1 (tens) in [7:4], and so on.
- busy, output, 1: a conversion is in progress.
- done, output, 1: one-cycle pulse; bcd_out and overflow updated this cycle.
- overflow, output, 1: the last result exceeded 10^DIGITS-1; bcd_out holds the low DIGITS digits.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bcd_out=0, busy=0, done=0, overflow=0.
  - FSM=IDLE, shift register=0, scratch=0, bit counter=0.
  - Reset takes effect immediately, mid-conversion included; the partial conversion is discarded and no done pulse is issued.
- Internal state:
  - Shift register: IN_WIDTH bits.
  - BCD scratch: 4*DIGITS bits.
  - Sticky overflow bit.
  - Bit counter: $clog2(IN_WIDTH+1) bits.
- IDLE:
  - On an edge with start=1: load sum_in into the shift register, clear scratch and the sticky bit, set counter=IN_WIDTH, set busy=1, go to SHIFT.
  - With start=0: hold; all outputs keep their values, except done, which is 0.
- SHIFT (one bit per edge):
  - Step 1: every scratch digit >= 5 gets +3, computed combinationally within the same cycle.
  - Step 2: the adjusted {scratch, shift register} shifts left by 1. The MSB of the shift register enters scratch bit 0. The bit shifted out of the scratch MSB ORs into the sticky overflow bit.
  - Counter decrements by 1.
  - On the edge where the counter goes from 1 to 0:
    - bcd_out <= final scratch; overflow <= sticky bit, also ORed with the condition scratch top digit >= 10 after the final shift.
    - done <= 1 for exactly one cycle; busy <= 0; FSM -> IDLE.
- Latency:
  - start sampled at edge E0; busy is high from E0.
  - Shifts occur at edges E1..E_IN_WIDTH. For the default this is E1..E5.
  - done is high in the cycle after E_IN_WIDTH, and bcd_out is valid in that same cycle.
  - Total: IN_WIDTH+1 edges from start to done.
- Handshake:
  - start while busy=1 is ignored; sum_in changes while busy have no effect.
  - start asserted in the done cycle is accepted (back-to-back). One conversion per IN_WIDTH+1 cycles maximum.
  - start held high continuously gives repeated conversions. Each samples sum_in at its own acceptance edge.
- bcd_out and overflow hold their values between completions. They are never partially updated.
- Arithmetic:
  - Each scratch digit stays within 0..9 before adjustment, except in the overflow case.
  - For the default, 31 -> 0x31, overflow=0. Overflow can only occur when IN_WIDTH > 3.32*DIGITS.
- Value 0: takes the full IN_WIDTH shifts, no early exit. Result bcd_out=0.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, start=0 for 10 cycles -> bcd_out=0x00, busy=0, done never pulses, overflow=0.
- Exhaustive default: for each sum_in 0..31, pulse start, wait for done -> bcd_out equals the decimal digits (19 -> 0x19, 30 -> 0x30, 31 -> 0x31). done is exactly 1 cycle wide, 6 edges after start. busy is high for exactly 5 cycles. overflow=0 throughout.
- Start while busy: start with sum_in=12, then re-pulse start with sum_in=27 on edge E2 -> the second start is ignored. bcd_out=0x12 at done, with a single done pulse.
- Back-to-back: start with sum_in=7, hold start=1 with sum_in=25 in the done cycle -> first done shows 0x07; the next done follows 6 edges later showing 0x25, with busy low for only the done cycle.
- Reset mid-conversion: start with sum_in=29, drop rst_n asynchronously between E3 and E4 -> outputs clear immediately and no done pulse. After release, start with sum_in=5 -> 0x05.
- Overflow (IN_WIDTH=7, DIGITS=2):
  - sum_in=127 -> bcd_out=0x27, overflow=1, done 8 edges after start.
  - sum_in=99 -> bcd_out=0x99, overflow=0.
